// File: rtl/bus_xfer_seq.sv
`default_nettype none
// ----------------------------------------------------------------------------
// bus_xfer_seq : sequences one source->destination register transfer as
// SETUP / STROBE / HOLD phases of PH_LEN cycles, driving one-hot ENA/SET strobes.
// Revision: 1.0
// ----------------------------------------------------------------------------
module bus_xfer_seq #(
  parameter int PH_LEN = 2
) (
  input  logic        CLK,
  input  logic        RESETN,
  input  logic        REQ_VALID,
  output logic        REQ_READY,
  input  logic [3:0]  SRC,
  input  logic [3:0]  DST,
  output logic [15:0] ENA,
  output logic [15:0] SET,
  output logic        BUSY,
  output logic        DONE,
  output logic        ERR,
  output logic [7:0]  XFER_CNT
);

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_SETUP  = 3'd1,
    S_STROBE = 3'd2,
    S_HOLD   = 3'd3,
    S_FIN    = 3'd4,
    S_REJ    = 3'd5
  } state_t;

  localparam logic [3:0] PH_RELOAD = 4'(PH_LEN - 1);

  state_t     state;
  logic [3:0] phase;
  logic [3:0] src_q;
  logic [3:0] dst_q;
  logic       src_ok;
  logic       dst_ok;
  logic       cmd_ok;

  assign src_ok = (SRC inside {4'd1, 4'd2, 4'd3, 4'd4, 4'd5, 4'd7});
  assign dst_ok = (DST inside {4'd2, 4'd3, 4'd4, 4'd5, 4'd6, 4'd7});
  assign cmd_ok = src_ok && dst_ok && (SRC != DST);

  assign REQ_READY = (state == S_IDLE);
  assign BUSY      = (state != S_IDLE);

  // Strobes are registered alongside the state so they change on the same edge.
  always_ff @(posedge CLK or negedge RESETN) begin
    if (!RESETN) begin
      state    <= S_IDLE;
      phase    <= 4'd0;
      src_q    <= 4'd0;
      dst_q    <= 4'd0;
      ENA      <= 16'd0;
      SET      <= 16'd0;
      DONE     <= 1'b0;
      ERR      <= 1'b0;
      XFER_CNT <= 8'd0;
    end else begin
      case (state)
        S_IDLE: begin
          if (REQ_VALID) begin
            src_q <= SRC;
            dst_q <= DST;
            if (cmd_ok) begin
              state <= S_SETUP;
              phase <= PH_RELOAD;
              ENA   <= 16'd1 << SRC;
            end else begin
              state <= S_REJ;
              ERR   <= 1'b1;
            end
          end
        end
        S_SETUP: begin
          if (phase == 4'd0) begin
            state <= S_STROBE;
            phase <= PH_RELOAD;
            SET   <= 16'd1 << dst_q;
          end else begin
            phase <= phase - 4'd1;
          end
        end
        S_STROBE: begin
          if (phase == 4'd0) begin
            state <= S_HOLD;
            phase <= PH_RELOAD;
            SET   <= 16'd0;
          end else begin
            phase <= phase - 4'd1;
          end
        end
        S_HOLD: begin
          if (phase == 4'd0) begin
            state <= S_FIN;
            ENA   <= 16'd0;
            DONE  <= 1'b1;
          end else begin
            phase <= phase - 4'd1;
          end
        end
        S_FIN: begin
          state    <= S_IDLE;
          DONE     <= 1'b0;
          XFER_CNT <= XFER_CNT + 8'd1;
        end
        S_REJ: begin
          state <= S_IDLE;
          ERR   <= 1'b0;
        end
        default: begin
          state <= S_IDLE;
          ENA   <= 16'd0;
          SET   <= 16'd0;
          DONE  <= 1'b0;
          ERR   <= 1'b0;
        end
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_bus_xfer_seq.sv
`default_nettype none
// ----------------------------------------------------------------------------
// tb_bus_xfer_seq : directed scenarios against bus_xfer_seq (PH_LEN=2 and 1).
// Revision: 1.0
// ----------------------------------------------------------------------------
module tb_bus_xfer_seq;

  logic        CLK = 1'b0;
  logic        RESETN;
  logic        req_valid, req_valid1;
  logic [3:0]  src, dst, src1, dst1;
  logic        req_ready, req_ready1;
  logic [15:0] ena, set, ena1, set1;
  logic        busy, done, err, busy1, done1, err1;
  logic [7:0]  xfer_cnt, xfer_cnt1;

  int n_cmp = 0;
  int n_err = 0;

  always #5 CLK = ~CLK;

  bus_xfer_seq #(.PH_LEN(2)) dut (
    .CLK(CLK), .RESETN(RESETN), .REQ_VALID(req_valid), .REQ_READY(req_ready),
    .SRC(src), .DST(dst), .ENA(ena), .SET(set), .BUSY(busy), .DONE(done),
    .ERR(err), .XFER_CNT(xfer_cnt)
  );

  bus_xfer_seq #(.PH_LEN(1)) dut1 (
    .CLK(CLK), .RESETN(RESETN), .REQ_VALID(req_valid1), .REQ_READY(req_ready1),
    .SRC(src1), .DST(dst1), .ENA(ena1), .SET(set1), .BUSY(busy1), .DONE(done1),
    .ERR(err1), .XFER_CNT(xfer_cnt1)
  );

  task automatic step;
    @(posedge CLK);
    #1;
  endtask

  task automatic test_reset;
    RESETN = 1'b0; req_valid = 0; src = 0; dst = 0;
    req_valid1 = 0; src1 = 0; dst1 = 0;
    #1;
    n_cmp++;
    if ({ena, set, busy, done, err, xfer_cnt, req_ready} !== {16'd0, 16'd0, 1'b0, 1'b0, 1'b0, 8'd0, 1'b1}) begin
      n_err++;
      $display("FAIL reset_state: ena=%h set=%h busy=%b done=%b err=%b cnt=%0d rdy=%b, want 0 0 0 0 0 0 1",
               ena, set, busy, done, err, xfer_cnt, req_ready);
    end
    #1 RESETN = 1'b1;
  endtask

  // Legal transfer on the PH_LEN=2 instance, accepted on the next edge.
  task automatic run_legal(input logic [3:0] s, input logic [3:0] d,
                           input logic [15:0] e_ena, input logic [15:0] e_set,
                           input logic [7:0] cnt0, input bit chg);
    req_valid = 1; src = s; dst = d;
    for (int k = 1; k <= 8; k++) begin
      step();
      if (k == 1) req_valid = 0;
      if (chg && k == 3) begin src = 4'd5; dst = 4'd6; end
      n_cmp++;
      if (ena !== ((k >= 1 && k <= 6) ? e_ena : 16'd0)) begin
        n_err++; $display("FAIL ena_c%0d: got %h want %h", k, ena, (k <= 6) ? e_ena : 16'd0);
      end
      n_cmp++;
      if (set !== ((k == 3 || k == 4) ? e_set : 16'd0)) begin
        n_err++; $display("FAIL set_c%0d: got %h want %h", k, set, (k == 3 || k == 4) ? e_set : 16'd0);
      end
      n_cmp++;
      if ({done, busy, req_ready, err} !== {(k == 7), (k <= 7), (k == 8), 1'b0}) begin
        n_err++; $display("FAIL ctl_c%0d: done/busy/rdy/err=%b%b%b%b want %b%b%b0",
                          k, done, busy, req_ready, err, (k == 7), (k <= 7), (k == 8));
      end
    end
    n_cmp++;
    if (xfer_cnt !== cnt0 + 8'd1) begin
      n_err++; $display("FAIL xfer_cnt: got %0d want %0d", xfer_cnt, cnt0 + 8'd1);
    end
  endtask

  task automatic test_basic;
    run_legal(4'd1, 4'd2, 16'h0002, 16'h0004, 8'd0, 1'b0);
  endtask

  task automatic test_latch;
    run_legal(4'd7, 4'd4, 16'h0080, 16'h0010, 8'd1, 1'b1);
  endtask

  task automatic test_illegal;
    logic [7:0] pairs [4];
    pairs[0] = 8'h33; pairs[1] = 8'h21; pairs[2] = 8'h02; pairs[3] = 8'h82;
    for (int i = 0; i < 4; i++) begin
      req_valid = 1; src = pairs[i][7:4]; dst = pairs[i][3:0];
      step();
      req_valid = 0;
      n_cmp++;
      if ({err, busy, done, ena, set} !== {1'b1, 1'b1, 1'b0, 16'd0, 16'd0}) begin
        n_err++; $display("FAIL rej_%h: err=%b busy=%b done=%b ena=%h set=%h want 1 1 0 0 0",
                          pairs[i], err, busy, done, ena, set);
      end
      step();
      n_cmp++;
      if ({err, req_ready, ena, set, xfer_cnt} !== {1'b0, 1'b1, 16'd0, 16'd0, 8'd2}) begin
        n_err++; $display("FAIL rej_end_%h: err=%b rdy=%b ena=%h set=%h cnt=%0d want 0 1 0 0 2",
                          pairs[i], err, req_ready, ena, set, xfer_cnt);
      end
    end
  endtask

  task automatic test_reset_mid;
    req_valid = 1; src = 4'd1; dst = 4'd2;
    step(); req_valid = 0;
    step(); step();
    n_cmp++;
    if (set !== 16'h0004) begin
      n_err++; $display("FAIL pre_rst_strobe: set=%h want 0004", set);
    end
    #2 RESETN = 1'b0;
    #1;
    n_cmp++;
    if ({ena, set, busy, done, xfer_cnt} !== {16'd0, 16'd0, 1'b0, 1'b0, 8'd0}) begin
      n_err++; $display("FAIL async_rst: ena=%h set=%h busy=%b done=%b cnt=%0d want 0 0 0 0 0",
                        ena, set, busy, done, xfer_cnt);
    end
    #2 RESETN = 1'b1;
    #1;
    n_cmp++;
    if (req_ready !== 1'b1) begin
      n_err++; $display("FAIL rdy_after_rst: got %b want 1", req_ready);
    end
    for (int k = 0; k < 8; k++) begin
      step();
      n_cmp++;
      if ({done, busy, xfer_cnt} !== {1'b0, 1'b0, 8'd0}) begin
        n_err++; $display("FAIL post_rst_c%0d: done=%b busy=%b cnt=%0d want 0 0 0", k, done, busy, xfer_cnt);
      end
    end
  endtask

  task automatic test_back_to_back;
    req_valid = 1; src = 4'd1; dst = 4'd2;
    for (int i = 0; i < 256; i++) begin
      for (int k = 1; k <= 8; k++) begin
        step();
        if (k == 1) begin
          n_cmp++;
          if (ena !== 16'h0002) begin
            n_err++; $display("FAIL b2b_ena_start_%0d: got %h want 0002", i, ena);
          end
        end
        if (k == 7) begin
          n_cmp++;
          if (done !== 1'b1) begin
            n_err++; $display("FAIL b2b_done_%0d: got %b want 1", i, done);
          end
        end
        if (k == 8) begin
          n_cmp++;
          if ({ena, req_ready, xfer_cnt} !== {16'd0, 1'b1, 8'(i + 1)}) begin
            n_err++; $display("FAIL b2b_idle_%0d: ena=%h rdy=%b cnt=%0d want 0 1 %0d",
                              i, ena, req_ready, xfer_cnt, 8'(i + 1));
          end
          if (i == 255) req_valid = 0;
        end
      end
    end
    n_cmp++;
    if (xfer_cnt !== 8'd0) begin
      n_err++; $display("FAIL b2b_wrap: got %0d want 0", xfer_cnt);
    end
  endtask

  task automatic test_ph1;
    req_valid1 = 1; src1 = 4'd7; dst1 = 4'd6;
    for (int k = 1; k <= 5; k++) begin
      step();
      if (k == 1) req_valid1 = 0;
      n_cmp++;
      if ({ena1, set1, done1, req_ready1} !==
          {((k <= 3) ? 16'h0080 : 16'd0), ((k == 2) ? 16'h0040 : 16'd0), (k == 4), (k == 5)}) begin
        n_err++; $display("FAIL ph1_c%0d: ena=%h set=%h done=%b rdy=%b", k, ena1, set1, done1, req_ready1);
      end
    end
    n_cmp++;
    if (xfer_cnt1 !== 8'd1) begin
      n_err++; $display("FAIL ph1_cnt: got %0d want 1", xfer_cnt1);
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_latch();
    test_illegal();
    test_reset_mid();
    test_back_to_back();
    test_ph1();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/bus_xfer_seq.md
BUS_XFER_SEQ -- requirements
Module: bus_xfer_seq

Interface
REQ-001 Parameter PH_LEN, default 2, SHALL set the cycles per transfer phase (legal 1..15).
REQ-002 Port CLK  in  1  SHALL be the system clock; all state changes on its rising edge.
REQ-003 Port RESETN  in  1  SHALL be the reset: asynchronous, active-low.
REQ-004 Port REQ_VALID  in  1  SHALL indicate a transfer command is presented.
REQ-005 Port REQ_READY  out  1  SHALL indicate the block accepts a command this cycle.
REQ-006 Port SRC  in  4  SHALL carry the source code (DATA=1, R0=2, R1=3, R2=4, R3=5, TMP=6, ACC=7).
REQ-007 Port DST  in  4  SHALL carry the destination code, same encoding.
REQ-008 Port ENA  out  16  SHALL carry the one-hot bus-enable strobe, bit index = latched SRC.
REQ-009 Port SET  out  16  SHALL carry the one-hot register-set strobe, bit index = latched DST.
REQ-010 Port BUSY  out  1  SHALL be high whenever the state is not IDLE.
REQ-011 Port DONE  out  1  SHALL pulse one cycle at transfer completion.
REQ-012 Port ERR  out  1  SHALL pulse one cycle when an illegal command is rejected.
REQ-013 Port XFER_CNT  out  8  SHALL count completed transfers.

Function
REQ-014 States SHALL be IDLE, SETUP, STROBE, HOLD, FIN, REJ; all outputs SHALL be decoded from registered state/latches (no combinational path from inputs to outputs except none; REQ_READY depends on state only).
REQ-015 REQ_READY SHALL be 1 in IDLE only.
REQ-016 Acceptance SHALL occur on a rising edge with REQ_VALID=1 and REQ_READY=1; SRC and DST SHALL be latched then, later input changes ignored until IDLE.
REQ-017 Legal SRC set: DATA, R0-R3, ACC. Legal DST set: R0-R3, TMP, ACC. SRC==DST SHALL be illegal; codes 0 and 8-15 SHALL be illegal.
REQ-018 Legal accept SHALL go IDLE->SETUP; illegal accept SHALL go IDLE->REJ.
REQ-019 SETUP, STROBE, HOLD SHALL each last exactly PH_LEN cycles, timed by an internal phase counter reloaded on each state entry.
REQ-020 ENA[SRC] SHALL be 1 throughout SETUP, STROBE, HOLD; all other ENA bits 0.
REQ-021 SET[DST] SHALL be 1 throughout STROBE only; all other SET bits 0.
REQ-022 HOLD SHALL transition to FIN; FIN SHALL last one cycle with DONE=1, then go to IDLE.
REQ-023 REJ SHALL last one cycle with ERR=1, ENA=0, SET=0, then go to IDLE.
REQ-024 XFER_CNT SHALL increment by 1 on leaving FIN, wrapping 255->0; rejects SHALL NOT count.
REQ-025 Legal transfer latency SHALL be 3*PH_LEN+1 busy cycles after acceptance; back-to-back commands SHALL have one IDLE cycle between transfers.
REQ-026 SET SHALL never assert in a cycle where ENA is 0 (setup/hold around strobe guaranteed by SETUP/HOLD).

Reset
REQ-027 RESETN=0 SHALL immediately force state IDLE, ENA=0, SET=0, DONE=0, ERR=0, BUSY=0, XFER_CNT=0, phase counter 0, latches 0, irrespective of CLK.
REQ-028 Reset mid-transfer SHALL abort it with no DONE and no count increment; REQ_READY SHALL be 1 after RESETN is released.
REQ-029 The first acceptance SHALL be possible on the first rising edge with RESETN=1.

Verification
REQ-030 PH_LEN=2, SRC=1, DST=2 accepted at edge 0 -> ENA=0x0002 cycles 1-6, SET=0x0004 cycles 3-4, DONE cycle 7, REQ_READY cycle 8, XFER_CNT=1.
REQ-031 SRC=3, DST=3 -> ERR one cycle after accept, ENA=SET=0 throughout, XFER_CNT unchanged; SRC=2, DST=1 (DATA destination) -> same.
REQ-032 SRC/DST changed to 5/6 during STROBE of a 7->4 transfer -> ENA stays 0x0080, SET stays 0x0010 to completion.
REQ-033 RESETN pulsed low during STROBE -> ENA, SET, BUSY drop to 0 asynchronously; no DONE; XFER_CNT=0.
REQ-034 256 consecutive legal transfers with REQ_VALID held high -> XFER_CNT wraps to 0; one IDLE cycle between each DONE and next ENA.
REQ-035 PH_LEN=1, SRC=7, DST=6 -> ENA cycles 1-3, SET cycle 2, DONE cycle 4.
